dbg_reg_select: RTL and testbench
=================================

// Module: dbg_reg_select
// PURPOSE
//  Upstream feeder of the debug LCD driver. Debounces two pushbuttons that step a
//  register index, then selects one byte from the 80-bit CPU debug bus (CPU mode) or
//  passes the RAM probe address/data through (RAM mode). Outputs are latched
//  snapshots, refreshed at a slow rate so the LCD never shows a torn value.
// PARAMETERS
//  DEBOUNCE_CYCLES  500000   cycles a button input must stay stable to be accepted (10 ms @ 50 MHz)
//  REFRESH_CYCLES   2097152  snapshot refresh period in cycles; must be >= 2
//  NUM_REGS         10       number of selectable registers (indices 0..NUM_REGS-1, max 16)
// PORTS
//  qzt_clk        in   1   system clock
//  rst_n          in   1   reset: asynchronous assert, active-low
//  btn_next       in   1   raw pushbutton, active-high, asynchronous: next register
//  btn_prev       in   1   raw pushbutton, active-high, asynchronous: previous register
//  switchFlag     in   1   1 = RAM debug mode, 0 = CPU debug mode (quasi-static)
//  freeze         in   1   1 = hold all snapshot outputs
//  CPU_interface  in   80  byte k = CPU_interface[8k+7:8k]: 0 PCh,1 PCl,2 A,3 B,4 C,5 D,6 E,7 H,8 L,9 flags
//  mem_addr       in   8   RAM probe address
//  mem_data       in   8   RAM probe data
//  dbg_reg_addr   out  4   selected register index (live, not snapshotted)
//  addrInput      out  8   snapshot: mem_addr (RAM mode), {4'b0,dbg_reg_addr} (CPU mode)
//  dataInput      out  8   snapshot: mem_data (RAM mode), selected CPU byte (CPU mode)
//  snap_upd       out  1   one-cycle pulse in the cycle after addrInput/dataInput update
// BEHAVIOUR
//  Reset (async, rst_n=0): dbg_reg_addr=0, addrInput=0, dataInput=0, snap_upd=0.
//   Debounce counters, synchronizers and the refresh timer clear. Stable button state = 0.
//   Reset in mid-debounce or mid-refresh discards the partial count.
//  Button path (per button): 2-FF synchronizer, then debounce.
//   - Counter resets on every change of the synchronized level.
//   - The stable level updates after DEBOUNCE_CYCLES consecutive equal samples.
//   - A 0->1 change of the stable level produces a one-cycle press pulse.
//   - Release produces no pulse. Holding the button gives exactly one step.
//  Index update, in the cycle after the press pulse:
//   - next only: idx = (idx==NUM_REGS-1) ? 0 : idx+1
//   - prev only: idx = (idx==0) ? NUM_REGS-1 : idx-1
//   - next and prev in the same cycle: no change
//   - The index steps in both modes. In RAM mode it only affects CPU-mode output.
//  Refresh timer:
//   - Free-running, counts 0..REFRESH_CYCLES-1.
//   - tick=1 when count==REFRESH_CYCLES-1, then the timer wraps to 0.
//  Snapshot load condition: (tick OR index changed last cycle OR switchFlag changed) AND !freeze.
//   - The load captures the current-cycle inputs. Latency from condition to outputs is 1 cycle.
//   - snap_upd is high in the cycle the new outputs are first visible.
//   - The CPU byte mux uses the already-updated index, so a button step shows its new register
//     on the next load, at most 2 cycles after the press pulse.
//   - Index >= NUM_REGS can occur only with NUM_REGS not matching the bus. Such an index selects
//     data 8'h00 and never traps.
//   - While freeze=1, no load and no snap_upd. The timer and index keep running.
//     The first tick after freeze falls applies the load condition normally.
//  switchFlag is sampled through a 2-FF synchronizer. "Changed" means the synchronized value differs
//   from its last-cycle value.
//  Counter widths are $clog2 of the parameter. Comparisons are unsigned. There is no overflow
//   beyond the terminal counts.
// STRUCTURE
//  Shared package dbg_pkg:
//   - DBG_NUM_REGS
//   - register index localparams REG_PCH..REG_FLAGS
//   - the byte-lane layout of CPU_interface. The LCD driver uses the same package for its name table.
//  Sub-module btn_debounce (params DEBOUNCE_CYCLES; ports qzt_clk, rst_n, btn_raw -> press):
//   - contains the synchronizer, counter and edge detect
//   - instantiated twice
//  Top level holds the index register, refresh timer, mode synchronizer and snapshot registers.
// TESTING
//  Use DEBOUNCE_CYCLES=8, REFRESH_CYCLES=64 throughout.
//  1. Reset, then run 64 cycles with CPU_interface byte0=8'h12 -> dbg_reg_addr=0, first tick gives
//     dataInput=8'h12, addrInput=8'h00, snap_upd high 1 cycle.
//  2. btn_next glitches 0/1 every 3 cycles for 30 cycles, then held high 20 cycles -> exactly one step,
//     dbg_reg_addr=1, dataInput=byte1 within 2 cycles of the press pulse.
//  3. Nine clean next presses from idx 1 -> wraps to 0. One prev press at 0 -> idx 9,
//     dataInput=byte9 (flags).
//  4. next and prev released-to-pressed on the same cycle -> index unchanged, no snapshot load
//     beyond the normal tick.
//  5. switchFlag=1, mem_addr=8'hA5, mem_data=8'h3C -> after sync+1 cycle addrInput=8'hA5,
//     dataInput=8'h3C. Then freeze=1 and change mem_data to 8'hFF for 200 cycles -> dataInput stays
//     8'h3C, no snap_upd.
//  6. Assert rst_n=0 mid-debounce and mid-refresh -> all outputs 0 asynchronously. After release,
//     the held button needs a full DEBOUNCE_CYCLES before a step.

Source files
------------

// File: rtl/dbg_pkg.sv
// Shared definitions for the debug register selector and the LCD driver:
// register count, register index names and the byte-lane layout of the
// 80-bit CPU debug bus.
package dbg_pkg;

    localparam int DBG_NUM_REGS = 10;
    localparam int DBG_BUS_W    = 8 * DBG_NUM_REGS;

    localparam logic [3:0] REG_PCH   = 4'd0;
    localparam logic [3:0] REG_PCL   = 4'd1;
    localparam logic [3:0] REG_A     = 4'd2;
    localparam logic [3:0] REG_B     = 4'd3;
    localparam logic [3:0] REG_C     = 4'd4;
    localparam logic [3:0] REG_D     = 4'd5;
    localparam logic [3:0] REG_E     = 4'd6;
    localparam logic [3:0] REG_H     = 4'd7;
    localparam logic [3:0] REG_L     = 4'd8;
    localparam logic [3:0] REG_FLAGS = 4'd9;

    typedef enum logic {
        MODE_CPU = 1'b0,
        MODE_RAM = 1'b1
    } dbg_mode_e;

    // Byte k of the CPU bus sits in bits [8k+7:8k]; indices without a lane read as zero.
    function automatic logic [7:0] cpu_byte(input logic [DBG_BUS_W-1:0] bus, input logic [3:0] idx);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            REG_PCH:   b = bus[7:0];
            REG_PCL:   b = bus[15:8];
            REG_A:     b = bus[23:16];
            REG_B:     b = bus[31:24];
            REG_C:     b = bus[39:32];
            REG_D:     b = bus[47:40];
            REG_E:     b = bus[55:48];
            REG_H:     b = bus[63:56];
            REG_L:     b = bus[71:64];
            REG_FLAGS: b = bus[79:72];
            default:   b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/dbg_reg_select_if.sv
// Signal bundle between the debug register selector and its surroundings:
// buttons, mode/freeze controls, the probe buses and the snapshot outputs.
interface dbg_reg_select_if;
    import dbg_pkg::*;

    logic                 btn_next;
    logic                 btn_prev;
    logic                 switchFlag;
    logic                 freeze;
    logic [DBG_BUS_W-1:0] CPU_interface;
    logic [7:0]           mem_addr;
    logic [7:0]           mem_data;
    logic [3:0]           dbg_reg_addr;
    logic [7:0]           addrInput;
    logic [7:0]           dataInput;
    logic                 snap_upd;

    modport master (
        output btn_next, btn_prev, switchFlag, freeze, CPU_interface, mem_addr, mem_data,
        input  dbg_reg_addr, addrInput, dataInput, snap_upd
    );

    modport slave (
        input  btn_next, btn_prev, switchFlag, freeze, CPU_interface, mem_addr, mem_data,
        output dbg_reg_addr, addrInput, dataInput, snap_upd
    );

endinterface

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: two-flop synchronizer, stability counter and a
// rising-edge detector that emits one press pulse per accepted 0->1 change.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic qzt_clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press
);

    localparam int            CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_meta;
    logic          sync_lvl;
    logic          sync_last;
    logic [CW-1:0] cnt;
    logic          stable;
    logic          stable_last;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge qzt_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            sync_lvl  <= 1'b0;
        end else begin
            sync_meta <= btn_raw;
            sync_lvl  <= sync_meta;
        end
    end

    // Restart the count on any level change; accept the level once the count saturates.
    always_ff @(posedge qzt_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_last   <= 1'b0;
            cnt         <= '0;
            stable      <= 1'b0;
            stable_last <= 1'b0;
        end else begin
            sync_last   <= sync_lvl;
            stable_last <= stable;
            if (sync_lvl != sync_last) begin
                cnt <= '0;
            end else if (cnt != CNT_LAST) begin
                cnt <= cnt + 1'b1;
            end else begin
                stable <= sync_last;
            end
        end
    end

    assign press = stable & ~stable_last;

endmodule

// File: rtl/dbg_reg_select.sv
// Debug register selector feeding the LCD driver. Two debounced buttons step
// a register index; a slow refresh timer, index steps and mode changes load a
// snapshot of either the selected CPU byte or the RAM probe address/data.
module dbg_reg_select
    import dbg_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REFRESH_CYCLES  = 2097152,
    parameter int NUM_REGS        = DBG_NUM_REGS
) (
    input logic              qzt_clk,
    input logic              rst_n,
    dbg_reg_select_if.slave  bus
);

    localparam int            RW           = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);
    localparam logic [3:0]    IDX_LAST     = 4'(NUM_REGS - 1);
    localparam logic [4:0]    IDX_LIMIT    = 5'(NUM_REGS);

    logic          press_next;
    logic          press_prev;
    logic [3:0]    idx;
    logic [3:0]    idx_next;
    logic [3:0]    idx_prev;
    logic          idx_changed;
    logic [RW-1:0] refresh_cnt;
    logic          tick;
    logic          sw_meta;
    logic          sw_sync;
    logic          sw_last;
    logic          sw_changed;
    dbg_mode_e     mode;
    logic [7:0]    sel_byte;
    logic          load;
    logic [7:0]    addr_q;
    logic [7:0]    data_q;
    logic          upd_q;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_next (
        .qzt_clk (qzt_clk),
        .rst_n   (rst_n),
        .btn_raw (bus.btn_next),
        .press   (press_next)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_prev (
        .qzt_clk (qzt_clk),
        .rst_n   (rst_n),
        .btn_raw (bus.btn_prev),
        .press   (press_prev)
    );

    // Wrap-around index stepping; simultaneous next and prev cancel out.
    always_comb begin
        idx_next = idx;
        unique case ({press_next, press_prev})
            2'b10:   idx_next = (idx == IDX_LAST) ? 4'd0 : idx + 4'd1;
            2'b01:   idx_next = (idx == 4'd0) ? IDX_LAST : idx - 4'd1;
            default: idx_next = idx;
        endcase
    end

    // Index register plus its one-cycle history used to trigger a reload.
    always_ff @(posedge qzt_clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= 4'd0;
            idx_prev <= 4'd0;
        end else begin
            idx      <= idx_next;
            idx_prev <= idx;
        end
    end

    assign idx_changed = (idx != idx_prev);

    // Free-running refresh timer that wraps after its terminal count.
    always_ff @(posedge qzt_clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
        end else if (tick) begin
            refresh_cnt <= '0;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    assign tick = (refresh_cnt == REFRESH_LAST);

    // Synchronize the mode switch and keep last cycle's value for change detection.
    always_ff @(posedge qzt_clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta <= 1'b0;
            sw_sync <= 1'b0;
            sw_last <= 1'b0;
        end else begin
            sw_meta <= bus.switchFlag;
            sw_sync <= sw_meta;
            sw_last <= sw_sync;
        end
    end

    assign sw_changed = (sw_sync != sw_last);
    assign mode       = dbg_mode_e'(sw_sync);

    // Pick the CPU byte for the current index; indices beyond the register count read zero.
    always_comb begin
        sel_byte = 8'h00;
        if ({1'b0, idx} < IDX_LIMIT) begin
            sel_byte = cpu_byte(bus.CPU_interface, idx);
        end
    end

    assign load = (tick | idx_changed | sw_changed) & ~bus.freeze;

    // Snapshot registers, with a pulse marking the cycle fresh values first appear.
    always_ff @(posedge qzt_clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= 8'h00;
            data_q <= 8'h00;
            upd_q  <= 1'b0;
        end else begin
            upd_q <= load;
            if (load) begin
                if (mode == MODE_RAM) begin
                    addr_q <= bus.mem_addr;
                    data_q <= bus.mem_data;
                end else begin
                    addr_q <= {4'b0000, idx};
                    data_q <= sel_byte;
                end
            end
        end
    end

    assign bus.dbg_reg_addr = idx;
    assign bus.addrInput    = addr_q;
    assign bus.dataInput    = data_q;
    assign bus.snap_upd     = upd_q;

endmodule

// File: tb/tb_dbg_reg_select.sv
// Directed bench for the debug register selector with short debounce and
// refresh periods, checking each step against hand-computed values.
module tb_dbg_reg_select;

    logic qzt_clk;
    logic rst_n;
    int   nVectors;
    int   nMiscompares;
    int   steps;
    int   snaps;
    int   chgAt;
    bit   seen;
    bit   dataOk;
    logic [3:0] lastIdx;

    dbg_reg_select_if bus ();

    dbg_reg_select #(
        .DEBOUNCE_CYCLES (8),
        .REFRESH_CYCLES  (64)
    ) dut (
        .qzt_clk (qzt_clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    initial qzt_clk = 1'b0;
    always #5 qzt_clk = ~qzt_clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVectors++;
        assert (obs === exp) else begin
            nMiscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive both buttons, then count index steps and snapshot pulses over n cycles.
    task automatic applyStimulus(input logic nxt, input logic prv, input int n,
                                 output int stepCnt, output int snapCnt);
        logic [3:0] prevIdx;
        bus.btn_next = nxt;
        bus.btn_prev = prv;
        stepCnt = 0;
        snapCnt = 0;
        prevIdx = bus.dbg_reg_addr;
        for (int i = 0; i < n; i++) begin
            @(negedge qzt_clk);
            if (bus.dbg_reg_addr != prevIdx) stepCnt++;
            if (bus.snap_upd) snapCnt++;
            prevIdx = bus.dbg_reg_addr;
        end
    endtask

    // Wait, with a cycle budget, for the next snapshot pulse.
    task automatic waitSnap(input int maxCycles, output bit found);
        found = 1'b0;
        for (int i = 0; i < maxCycles && !found; i++) begin
            @(negedge qzt_clk);
            if (bus.snap_upd) found = 1'b1;
        end
    endtask

    initial begin
        int s;
        int p;
        nVectors     = 0;
        nMiscompares = 0;
        rst_n        = 1'b1;
        bus.btn_next = 1'b0;
        bus.btn_prev = 1'b0;
        bus.switchFlag = 1'b0;
        bus.freeze   = 1'b0;
        bus.mem_addr = 8'h00;
        bus.mem_data = 8'h00;
        for (int k = 0; k < 10; k++) bus.CPU_interface[8*k +: 8] = 8'h12 + 8'(k) * 8'h11;

        // Step 1: reset values and first refresh tick in CPU mode.
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_idx",  32'(bus.dbg_reg_addr), 32'h0);
        checkOutput("rst_addr", 32'(bus.addrInput),    32'h00);
        checkOutput("rst_data", 32'(bus.dataInput),    32'h00);
        checkOutput("rst_upd",  32'(bus.snap_upd),     32'h0);
        repeat (3) @(negedge qzt_clk);
        rst_n = 1'b1;
        waitSnap(70, seen);
        checkOutput("t1_tick_seen", 32'(seen),            32'h1);
        checkOutput("t1_data",      32'(bus.dataInput),   32'h12);
        checkOutput("t1_addr",      32'(bus.addrInput),   32'h00);
        checkOutput("t1_idx",       32'(bus.dbg_reg_addr), 32'h0);
        @(negedge qzt_clk);
        checkOutput("t1_upd_1cyc",  32'(bus.snap_upd),    32'h0);

        // Step 2: bouncing button never accepted, then a long hold gives one step.
        steps = 0;
        for (int i = 0; i < 30; i++) begin
            applyStimulus(((i / 3) % 2) == 0, 1'b0, 1, s, p);
            steps += s;
        end
        checkOutput("t2_glitch_steps", 32'(steps), 32'h0);
        bus.btn_next = 1'b1;
        chgAt   = -1;
        dataOk  = 1'b0;
        lastIdx = bus.dbg_reg_addr;
        for (int i = 0; i < 20; i++) begin
            @(negedge qzt_clk);
            if (bus.dbg_reg_addr != lastIdx) begin
                steps++;
                chgAt = i;
            end
            if (bus.snap_upd && chgAt >= 0 && (i - chgAt) <= 1 && bus.dataInput == 8'h23) dataOk = 1'b1;
            lastIdx = bus.dbg_reg_addr;
        end
        applyStimulus(1'b0, 1'b0, 20, s, p);
        steps += s;
        checkOutput("t2_hold_steps", 32'(steps),            32'h1);
        checkOutput("t2_idx",        32'(bus.dbg_reg_addr), 32'h1);
        checkOutput("t2_data_fast",  32'(dataOk),           32'h1);

        // Step 3: nine next presses wrap to 0, one prev press wraps to 9.
        steps = 0;
        for (int n = 0; n < 9; n++) begin
            applyStimulus(1'b1, 1'b0, 14, s, p);
            steps += s;
            applyStimulus(1'b0, 1'b0, 14, s, p);
            steps += s;
        end
        checkOutput("t3_next_steps", 32'(steps),            32'h9);
        checkOutput("t3_wrap_idx",   32'(bus.dbg_reg_addr), 32'h0);
        applyStimulus(1'b0, 1'b1, 14, s, p);
        applyStimulus(1'b0, 1'b0, 14, s, p);
        checkOutput("t3_prev_idx",   32'(bus.dbg_reg_addr), 32'h9);
        checkOutput("t3_flags_data", 32'(bus.dataInput),    32'hAB);
        checkOutput("t3_flags_addr", 32'(bus.addrInput),    32'h09);

        // Step 4: both buttons together cancel; at most one refresh tick in the window.
        applyStimulus(1'b1, 1'b1, 14, s, p);
        steps = s;
        snaps = p;
        applyStimulus(1'b0, 1'b0, 14, s, p);
        steps += s;
        snaps += p;
        checkOutput("t4_both_steps", 32'(steps),            32'h0);
        checkOutput("t4_idx",        32'(bus.dbg_reg_addr), 32'h9);
        checkOutput("t4_snaps_le1",  32'(snaps <= 1),       32'h1);

        // Step 5: RAM mode passthrough, then freeze holds the snapshot.
        bus.switchFlag = 1'b1;
        bus.mem_addr   = 8'hA5;
        bus.mem_data   = 8'h3C;
        applyStimulus(1'b0, 1'b0, 6, s, p);
        checkOutput("t5_mode_snap", 32'(p >= 1),         32'h1);
        checkOutput("t5_ram_addr",  32'(bus.addrInput),  32'hA5);
        checkOutput("t5_ram_data",  32'(bus.dataInput),  32'h3C);
        bus.freeze   = 1'b1;
        bus.mem_data = 8'hFF;
        applyStimulus(1'b0, 1'b0, 200, s, p);
        checkOutput("t5_frz_snaps", 32'(p),              32'h0);
        checkOutput("t5_frz_data",  32'(bus.dataInput),  32'h3C);
        bus.freeze = 1'b0;
        waitSnap(70, seen);
        checkOutput("t5_unfrz_seen", 32'(seen),           32'h1);
        checkOutput("t5_unfrz_data", 32'(bus.dataInput),  32'hFF);

        // Step 6: asynchronous reset mid-debounce; the held button restarts its full count.
        bus.btn_next = 1'b1;
        repeat (5) @(posedge qzt_clk);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_idx",  32'(bus.dbg_reg_addr), 32'h0);
        checkOutput("t6_rst_addr", 32'(bus.addrInput),    32'h00);
        checkOutput("t6_rst_data", 32'(bus.dataInput),    32'h00);
        checkOutput("t6_rst_upd",  32'(bus.snap_upd),     32'h0);
        @(negedge qzt_clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 8, s, p);
        checkOutput("t6_early_steps", 32'(s),                32'h0);
        applyStimulus(1'b1, 1'b0, 12, s, p);
        checkOutput("t6_late_steps",  32'(s),                32'h1);
        checkOutput("t6_idx",         32'(bus.dbg_reg_addr), 32'h1);
        applyStimulus(1'b0, 1'b0, 4, s, p);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
